// File: rtl/serial_cpa_pkg.sv
// Shared types and helpers for the serial carry-propagate adder.
package serial_cpa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Segment counter width; a single-segment build still needs one bit.
  function automatic int cnt_width(input int num_seg);
    int w;
    w = $clog2(num_seg);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the segment ripple chain.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/serial_cpa_cin_segment_adder.sv
// SEG_LEN-bit ripple adder with carry-in; result carries the carry-out in its MSB.
module cin_segment_adder #(
  parameter int SEG_LEN = 64
) (
  input  logic [SEG_LEN-1:0] a_i,
  input  logic [SEG_LEN-1:0] b_i,
  input  logic               cin_i,
  output logic [SEG_LEN:0]   sum_o
);

  logic [SEG_LEN:0]   carry;
  logic [SEG_LEN-1:0] bit_sum;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < SEG_LEN; i++) begin : g_fa
    full_adder u_fa (
      .a_i (a_i[i]),
      .b_i (b_i[i]),
      .c_i (carry[i]),
      .s_o (bit_sum[i]),
      .c_o (carry[i+1])
    );
  end

  assign sum_o = {carry[SEG_LEN], bit_sum};

endmodule

// File: rtl/serial_cpa.sv
// Multi-cycle carry-propagate adder: adds SEG_LEN bits per cycle with a registered carry.
// Optional macro SERIAL_CPA_EARLY_DONE_EN finishes early once the remaining upper segments are zero.
//
// Handshake: a transfer happens on a rising edge where valid && ready. in_ready and
// out_valid depend only on the FSM state; the producer/consumer may not retract valid
// before the transfer, and out_sum stays stable while out_valid is high.
module serial_cpa
  import serial_cpa_pkg::*;
#(
  parameter int BIT_LEN = 1024,
  parameter int SEG_LEN = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BIT_LEN-1:0] in_a,
  input  logic [BIT_LEN-1:0] in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BIT_LEN:0]   out_sum,
  output state_t             dbg_state
);

  localparam int NUM_SEG = BIT_LEN / SEG_LEN;
  localparam int CNT_W   = cnt_width(NUM_SEG);
  localparam logic [CNT_W-1:0] LAST_SEG = CNT_W'(NUM_SEG - 1);

  if ((BIT_LEN % SEG_LEN) != 0 || BIT_LEN < SEG_LEN) begin : g_bad_len
    $error("serial_cpa: BIT_LEN (%0d) must be a multiple of SEG_LEN (%0d)", BIT_LEN, SEG_LEN);
  end

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   seg_cnt_q, seg_cnt_d;
  logic               carry_q, carry_d;
  logic [BIT_LEN-1:0] a_q, a_d;
  logic [BIT_LEN-1:0] b_q, b_d;
  logic [BIT_LEN:0]   sum_q, sum_d;

  logic [SEG_LEN-1:0] seg_a;
  logic [SEG_LEN-1:0] seg_b;
  logic [SEG_LEN:0]   seg_res;
  logic               accept;
  logic               last_seg;
  logic               early_done;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_sum   = sum_q;
  assign dbg_state = state_q;

  assign accept   = in_valid && in_ready;
  assign last_seg = (seg_cnt_q == LAST_SEG);

  assign seg_a = a_q[int'(seg_cnt_q)*SEG_LEN +: SEG_LEN];
  assign seg_b = b_q[int'(seg_cnt_q)*SEG_LEN +: SEG_LEN];

  cin_segment_adder #(
    .SEG_LEN (SEG_LEN)
  ) u_seg_add (
    .a_i   (seg_a),
    .b_i   (seg_b),
    .cin_i (carry_q),
    .sum_o (seg_res)
  );

`ifdef SERIAL_CPA_EARLY_DONE_EN
  // upper_zero[i]: every operand bit above segment i is zero, so the sum is complete
  // after segment i provided that segment produces no carry.
  logic [NUM_SEG-1:0] upper_zero_in;
  logic [NUM_SEG-1:0] upper_zero_q;

  for (genvar i = 0; i < NUM_SEG; i++) begin : g_upz
    if (i == NUM_SEG - 1) begin : g_top
      assign upper_zero_in[i] = 1'b1;
    end else begin : g_low
      assign upper_zero_in[i] = ~|in_a[BIT_LEN-1:(i+1)*SEG_LEN] &
                                ~|in_b[BIT_LEN-1:(i+1)*SEG_LEN];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      upper_zero_q <= '0;
    end else if (accept) begin
      upper_zero_q <= upper_zero_in;
    end
  end

  assign early_done = upper_zero_q[seg_cnt_q] & ~seg_res[SEG_LEN];
`else
  assign early_done = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    seg_cnt_d = seg_cnt_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d       = in_a;
          b_d       = in_b;
          sum_d     = '0;
          seg_cnt_d = '0;
          carry_d   = 1'b0;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        sum_d[int'(seg_cnt_q)*SEG_LEN +: SEG_LEN] = seg_res[SEG_LEN-1:0];
        carry_d   = seg_res[SEG_LEN];
        seg_cnt_d = seg_cnt_q + CNT_W'(1);
        if (last_seg || early_done) begin
          sum_d[BIT_LEN] = seg_res[SEG_LEN];
          state_d        = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      seg_cnt_q <= '0;
      carry_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
    end else begin
      state_q   <= state_d;
      seg_cnt_q <= seg_cnt_d;
      carry_q   <= carry_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
    end
  end

endmodule

// File: tb/tb_serial_cpa.sv
// Self-checking bench for serial_cpa at BIT_LEN=256, SEG_LEN=64 against an arithmetic model.
module tb_serial_cpa;
  import serial_cpa_pkg::*;

  localparam int BIT_LEN = 256;
  localparam int SEG_LEN = 64;
  localparam int NUM_SEG = BIT_LEN / SEG_LEN;
  localparam int W       = BIT_LEN + 1;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [BIT_LEN-1:0] in_a = '0;
  logic [BIT_LEN-1:0] in_b = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [BIT_LEN:0]   out_sum;
  state_t             dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];

  serial_cpa #(
    .BIT_LEN (BIT_LEN),
    .SEG_LEN (SEG_LEN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .dbg_state (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model
  function automatic logic [W-1:0] ref_sum(input logic [BIT_LEN-1:0] a, input logic [BIT_LEN-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic int ref_latency(input logic [BIT_LEN-1:0] a, input logic [BIT_LEN-1:0] b);
    int lat;
    lat = NUM_SEG;
`ifdef SERIAL_CPA_EARLY_DONE_EN
    for (int k = NUM_SEG; k >= 1; k--) begin
      logic [W-1:0] mask;
      logic [W-1:0] lo;
      mask = (W'(1) << (k * SEG_LEN)) - W'(1);
      lo   = ({1'b0, a} & mask) + ({1'b0, b} & mask);
      if (((({1'b0, a} | {1'b0, b}) & ~mask) == '0) && (lo <= mask)) lat = k;
    end
`endif
    return lat;
  endfunction

  function automatic logic [BIT_LEN-1:0] rand_operand();
    logic [BIT_LEN-1:0] v;
    int mode;
    int keep;
    for (int i = 0; i < BIT_LEN / 32; i++) v[i*32 +: 32] = $urandom;
    mode = $urandom_range(0, 3);
    case (mode)
      1: v = BIT_LEN'(v[31:0]);
      2: v = '1;
      3: begin
        keep = $urandom_range(1, NUM_SEG);
        v = v & ((BIT_LEN'(1) << (keep * SEG_LEN)) - BIT_LEN'(1));
        if (keep == NUM_SEG) v = v | (BIT_LEN'(1) << (BIT_LEN - 1));
      end
      default: ;
    endcase
    return v;
  endfunction

  // driver tasks (all activity on the falling edge)
  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_op(input logic [BIT_LEN-1:0] a, input logic [BIT_LEN-1:0] b);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", W'(in_ready), W'(1));
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    exp_q.push_back(ref_sum(a, b));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called on the first falling edge after the accept edge.
  task automatic finish_op(input string tag, input int exp_lat, input int stall);
    int lat;
    logic [W-1:0] exp;
    lat = 0;
    while (!out_valid && lat < 4 * NUM_SEG) begin
      @(negedge clk);
      lat++;
    end
    exp = exp_q.pop_front();
    check({tag, "_latency"}, W'(lat), W'(exp_lat));
    check({tag, "_sum"}, out_sum, exp);
    check({tag, "_in_ready_done"}, W'(in_ready), W'(0));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, "_stall_sum"}, out_sum, exp);
      check({tag, "_stall_valid"}, W'(out_valid), W'(1));
      check({tag, "_stall_in_ready"}, W'(in_ready), W'(0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_post_valid"}, W'(out_valid), W'(0));
    check({tag, "_post_in_ready"}, W'(in_ready), W'(1));
    check({tag, "_post_sum_held"}, out_sum, exp);
  endtask

  initial begin
    logic [BIT_LEN-1:0] ones;
    logic [BIT_LEN-1:0] a;
    logic [BIT_LEN-1:0] b;
    logic [BIT_LEN-1:0] a2;
    logic [BIT_LEN-1:0] b2;
    ones = '1;

    // 1: reset held three cycles
    do_reset(3);
    check("reset_out_valid", W'(out_valid), W'(0));
    check("reset_in_ready", W'(in_ready), W'(1));
    check("reset_out_sum", out_sum, '0);

    // 2: full carry ripple
    start_op(ones, BIT_LEN'(1));
    finish_op("carry_ripple", NUM_SEG, 0);
    check("carry_ripple_value", out_sum, W'(1) << BIT_LEN);

    // 3: worst case with ten cycles of back-pressure
    start_op(ones, ones);
    finish_op("all_ones_stall", NUM_SEG, 10);
    check("all_ones_value", out_sum, (W'(1) << W) - W'(2));

    // 4: in_valid held during BUSY with a different pair
    a  = rand_operand();
    b  = rand_operand();
    a2 = rand_operand();
    b2 = rand_operand();
    start_op(a, b);
    in_valid = 1'b1;
    in_a     = a2;
    in_b     = b2;
    finish_op("busy_ignore", ref_latency(a, b), 2);
    exp_q.push_back(ref_sum(a2, b2));
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    finish_op("busy_second", ref_latency(a2, b2), 0);

    // 5: reset mid-operation, then a small add
    start_op(ones, ones);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    void'(exp_q.pop_front());
    check("abort_out_valid", W'(out_valid), W'(0));
    check("abort_in_ready", W'(in_ready), W'(1));
    check("abort_out_sum", out_sum, '0);
    start_op(BIT_LEN'(5), BIT_LEN'(7));
    finish_op("after_abort", ref_latency(BIT_LEN'(5), BIT_LEN'(7)), 0);
    check("after_abort_value", out_sum, W'(12));

    // small operands: single segment when early completion is built
    start_op(BIT_LEN'(3), BIT_LEN'(4));
    finish_op("small_add", ref_latency(BIT_LEN'(3), BIT_LEN'(4)), 0);
    check("small_add_value", out_sum, W'(7));

    // 6: random pairs with random back-pressure
    for (int n = 0; n < 500; n++) begin
      a = rand_operand();
      b = rand_operand();
      start_op(a, b);
      finish_op("random", ref_latency(a, b), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_cpa.md
Name: serial_cpa

Overview:
- Multi-cycle carry-propagate adder that turns a wide redundant pair (A, B) into a single binary sum, SEG_LEN bits per cycle.
- Sits downstream of the compressor tree, in place of a full-width combinational ripple adder, where a BIT_LEN-wide ripple chain would not close timing.
- Carry is registered between segments.
- Uses a valid/ready handshake on both sides. One operation is in flight at a time.

Parameters:
- BIT_LEN, 1024, operand width. Must be an integer multiple of SEG_LEN; any other value is an elaboration-time $error.
- SEG_LEN, 64, bits added per cycle; width of the segment adder.
- NUM_SEG, BIT_LEN/SEG_LEN, derived localparam, not overridable.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- in_a  input  BIT_LEN  operand A.
- in_b  input  BIT_LEN  operand B.
- out_valid  output  1  out_sum holds a complete result.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  BIT_LEN+1  A+B; MSB is the final carry.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- State machine: IDLE, BUSY, DONE.
- Reset (any state, any cycle): state=IDLE, seg_cnt=0, carry=0, out_sum=0, out_valid=0, in_ready=1.
- Outputs in_ready and out_valid are decoded from state only; no combinational path from in_valid or out_ready.
- IDLE:
  - in_ready=1.
  - Accept edge (in_valid&&in_ready): capture in_a and in_b into operand registers, clear out_sum to 0, seg_cnt=0, carry=0, go to BUSY.
- BUSY:
  - in_ready=0, out_valid=0.
  - Each edge: out_sum[seg_cnt*SEG_LEN +: SEG_LEN] <= low SEG_LEN bits of (a_seg + b_seg + carry). carry <= that sum's bit SEG_LEN. seg_cnt++.
  - On the edge where seg_cnt==NUM_SEG-1: also write the final carry into out_sum[BIT_LEN] and go to DONE.
- DONE:
  - out_valid=1; out_sum held stable.
  - Edge with out_ready=1: go to IDLE, out_valid=0. out_sum keeps its value until the next accept.
- Latency: out_valid is first high exactly NUM_SEG cycles after the accept edge.
- Throughput: one result per NUM_SEG+2 cycles minimum. Accepting in the same cycle as the DONE→IDLE handshake is not supported.
- Arithmetic:
  - Unsigned.
  - out_sum is exactly BIT_LEN+1 bits; there is no overflow.
  - Worst case is all-ones + all-ones = 2^(BIT_LEN+1)-2.
- in_valid while not IDLE: ignored. Operands are not sampled and no error is raised.
- in_a and in_b are sampled only on the accept edge; changes afterwards have no effect.
- Reset asserted mid-BUSY or in DONE: the in-flight operation is discarded. The next accepted operation yields the correct result.

Optional Feature:
- Macro: SERIAL_CPA_EARLY_DONE_EN.
- Defined:
  - In BUSY, if the next carry is 0 and all bits of both captured operands above the current segment are zero, go to DONE on this edge.
  - Upper out_sum bits stay 0 because out_sum was cleared at accept.
  - Latency becomes data-dependent, between 1 and NUM_SEG cycles.
  - Implement with a precomputed per-segment "upper-zero" vector registered at accept.
- Undefined: latency is always exactly NUM_SEG; no zero-detect logic is built.

Decomposition:
- Package serial_cpa_pkg:
  - state enum typedef (IDLE, BUSY, DONE);
  - function computing a counter width of clog2(NUM_SEG) with a minimum of 1.
- One sub-module, cin_segment_adder (SEG_LEN bits), built from the existing full_adder cell. It adds two SEG_LEN-bit operands plus a 1-bit carry-in and produces a SEG_LEN+1-bit result.
- Segment selection is an indexed part-select on the operand registers; a shift register is acceptable.

Test Plan:
All scenarios use BIT_LEN=256, SEG_LEN=64.
1. Reset held 3 cycles, then released → out_valid=0, in_ready=1, out_sum=0.
2. A=2^256-1, B=1 accepted at edge t → out_valid rises at t+4; out_sum=2^256 (bit 256=1, all other bits 0).
3. A=B=2^256-1, out_ready held 0 for 10 cycles in DONE → out_sum=2^257-2 stable throughout and in_ready=0; one cycle after out_ready=1, in_ready=1.
4. in_valid held high with different operands during BUSY → not captured; the first result is unchanged and the second pair is accepted only after returning to IDLE.
5. reset pulsed while seg_cnt=2, then A=5, B=7 → out_sum=12, with no residue from the aborted operation.
6. 500 random operand pairs with random out_ready back-pressure → every result equals the reference A+B. With SERIAL_CPA_EARLY_DONE_EN defined, A=3, B=4 completes in 1 cycle with out_sum=7.
